// File: rtl/apu_cluster_package.sv
// Shared constants for the APU cluster FP units.
// Result-buffer default depth is shared with the dispatcher.
package apu_cluster_package;
  localparam int FP_WIDTH       = 32;
  localparam int NUSFLAGS_MULT  = 5;
  localparam int FPRESBUF_DEPTH = 4;
endpackage

// File: rtl/fp_credit_counter.sv
// Issue credit counter: starts full, one credit per op in flight or stored.
// Reused by the adder, multiplier and divider result buffers.
module fp_credit_counter #(
  parameter int MAX = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc,
  input  logic dec,
  output logic ready,
  output logic err
);
  localparam int CW = $clog2(MAX + 1);

  logic [CW-1:0] credits;
  logic          take;

  assign ready = (credits != '0);
  assign take  = dec && ready;

  // Credit register; a take and a return in one cycle cancel out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      credits <= CW'(MAX);
    end else if (take && !inc) begin
      credits <= credits - 1'b1;
    end else if (inc && !take && credits != CW'(MAX)) begin
      credits <= credits + 1'b1;
    end
  end

  // Sticky flag for an issue attempted without a credit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err <= 1'b0;
    end else if (dec && !ready) begin
      err <= 1'b1;
    end
  end
endmodule

// File: rtl/fp_mult_result_buffer.sv
// Result FIFO behind the non-stalling FP multiplier, with issue credits.
// Optional FP_MULT_RESBUF_BYPASS_EN: empty-FIFO results pass through combinationally.
module fp_mult_result_buffer
  import apu_cluster_package::*;
#(
  parameter int DEPTH      = FPRESBUF_DEPTH,
  parameter int TAG_WIDTH  = 4,
  parameter int STAT_WIDTH = NUSFLAGS_MULT,
  parameter int FP_WIDTH   = apu_cluster_package::FP_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  Issue_i,
  output logic                  IssueReady_o,
  input  logic                  Valid_i,
  input  logic [FP_WIDTH-1:0]   Res_i,
  input  logic [TAG_WIDTH-1:0]  Tag_i,
  input  logic [STAT_WIDTH-1:0] Status_i,
  output logic                  Valid_o,
  output logic [FP_WIDTH-1:0]   Res_o,
  output logic [TAG_WIDTH-1:0]  Tag_o,
  output logic [STAT_WIDTH-1:0] Status_o,
  input  logic                  Ack_i,
  output logic                  Overflow_o,
  output logic                  IssueErr_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = STAT_WIDTH + TAG_WIDTH + FP_WIDTH;

  logic [DEPTH-1:0][EW-1:0] mem;
  logic [AW-1:0]            rd_ptr;
  logic [AW-1:0]            wr_ptr;
  logic [CW-1:0]            count;
  logic [EW-1:0]            in_entry;
  logic [EW-1:0]            out_entry;
  logic                     empty;
  logic                     full;
  logic                     pop;
  logic                     fifo_pop;
  logic                     push;

  assign in_entry = {Status_i, Tag_i, Res_i};
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));

`ifdef FP_MULT_RESBUF_BYPASS_EN
  logic byp;
  assign byp       = empty && Valid_i;
  assign Valid_o   = !empty || Valid_i;
  assign out_entry = byp ? in_entry : mem[rd_ptr];
  assign pop       = Valid_o && Ack_i;
  assign fifo_pop  = pop && !empty;
  assign push      = Valid_i && !(byp && Ack_i) && (!full || pop);
`else
  assign Valid_o   = !empty;
  assign out_entry = mem[rd_ptr];
  assign pop       = Valid_o && Ack_i;
  assign fifo_pop  = pop;
  assign push      = Valid_i && (!full || pop);
`endif

  assign {Status_o, Tag_o, Res_o} = out_entry;

  // Entry storage and write pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem    <= '0;
      wr_ptr <= '0;
    end else if (push) begin
      mem[wr_ptr] <= in_entry;
      wr_ptr      <= wr_ptr + AW'(1);
    end
  end

  // Read pointer and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, fifo_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: a result that found no slot was lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      Overflow_o <= 1'b0;
    end else if (Valid_i && full && !pop) begin
      Overflow_o <= 1'b1;
    end
  end

  fp_credit_counter #(
    .MAX (DEPTH)
  ) u_credits (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc    (pop),
    .dec    (Issue_i),
    .ready  (IssueReady_o),
    .err    (IssueErr_o)
  );
endmodule
